// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared types, default sizes and helpers for the interrupt fetch sequencer
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HANDLER = 2'd1,
    RETURN  = 2'd2
  } state_e;

  localparam int N_IRQ_DEF  = 4;
  localparam int ROM_AW_DEF = 6;
  localparam int PC_W_DEF   = 32;
  localparam int ID_W       = $clog2(N_IRQ_DEF);
  localparam int OFF_W      = ROM_AW_DEF - ID_W;

  // Wide enough for the largest supported request count (16 lines).
  function automatic logic [15:0] onehot(input logic [3:0] idx);
    onehot = 16'd1 << idx;
  endfunction

endpackage

// File: rtl/intc_seq_if.sv
// rtl/intc_seq_if.sv - request, fetch-steering and PC-restore signals of the interrupt sequencer
interface intc_seq_if #(
  parameter int N_IRQ  = 4,
  parameter int ROM_AW = 6,
  parameter int PC_W   = 32
);
  localparam int ID_W = $clog2(N_IRQ);

  logic [N_IRQ-1:0]  irq;
  logic [N_IRQ-1:0]  irq_mask;
  logic              ien;
  logic              stall;
  logic [PC_W-1:0]   pc_next;
  logic              handler_done;

  logic              sel_intc;
  logic [ROM_AW-1:0] rom_addr;
  logic [N_IRQ-1:0]  irq_ack;
  logic [ID_W-1:0]   irq_id;
  logic              pc_restore;
  logic [PC_W-1:0]   epc;
  logic              overrun;
  logic              busy;

  modport slave (
    input  irq, irq_mask, ien, stall, pc_next, handler_done,
    output sel_intc, rom_addr, irq_ack, irq_id, pc_restore, epc, overrun, busy
  );

  modport master (
    output irq, irq_mask, ien, stall, pc_next, handler_done,
    input  sel_intc, rom_addr, irq_ack, irq_id, pc_restore, epc, overrun, busy
  );

endinterface

// File: rtl/intc_prio_enc.sv
// rtl/intc_prio_enc.sv - combinational priority encoder, lowest index wins
module intc_prio_enc #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    pending,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scanning downwards lets the lowest set index overwrite any higher one.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/intc_seq.sv
// rtl/intc_seq.sv - interrupt fetch sequencer: arbitrate, save epc, walk handler slot, restore PC
module intc_seq
  import intc_pkg::*;
#(
  parameter int N_IRQ  = N_IRQ_DEF,
  parameter int ROM_AW = ROM_AW_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  intc_seq_if.slave   bus
);

  localparam int S_ID_W  = $clog2(N_IRQ);
  localparam int S_OFF_W = ROM_AW - S_ID_W;
  localparam logic [S_OFF_W-1:0] OFF_LAST = '1;

  logic [N_IRQ-1:0]   pending;
  logic               win_valid;
  logic [S_ID_W-1:0]  win_id;

  state_e             state_q, state_d;
  logic [S_OFF_W-1:0] off_q, off_d;
  logic [S_ID_W-1:0]  id_q, id_d;
  logic [PC_W-1:0]    epc_q, epc_d;
  logic [N_IRQ-1:0]   ack_q, ack_d;
  logic               ovr_q, ovr_d;

  assign pending = bus.ien ? (bus.irq & ~bus.irq_mask) : '0;

  intc_prio_enc #(
    .N    (N_IRQ),
    .ID_W (S_ID_W)
  ) u_prio (
    .pending (pending),
    .valid   (win_valid),
    .id      (win_id)
  );

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    id_d    = id_q;
    epc_d   = epc_q;
    // Pulses stretch across stalls so an unstalled consumer sees each once.
    ack_d   = bus.stall ? ack_q : '0;
    ovr_d   = bus.stall ? ovr_q : 1'b0;

    case (state_q)
      IDLE: begin
        if (win_valid && !bus.stall) begin
          epc_d   = bus.pc_next;
          id_d    = win_id;
          off_d   = '0;
          ack_d   = N_IRQ'(onehot(4'(win_id)));
          state_d = HANDLER;
        end
      end
      HANDLER: begin
        if (!bus.stall) begin
          if (bus.handler_done) begin
            state_d = RETURN;
          end else if (off_q == OFF_LAST) begin
            ovr_d   = 1'b1;
            state_d = RETURN;
          end else begin
            off_d = off_q + 1'b1;
          end
        end
      end
      RETURN: begin
        if (!bus.stall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      off_q   <= '0;
      id_q    <= '0;
      epc_q   <= '0;
      ack_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      id_q    <= id_d;
      epc_q   <= epc_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.sel_intc   = (state_q == HANDLER);
  assign bus.rom_addr   = {id_q, off_q};
  assign bus.irq_ack    = ack_q;
  assign bus.irq_id     = id_q;
  assign bus.pc_restore = (state_q == RETURN);
  assign bus.epc        = epc_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_intc_seq.sv
// tb/tb_intc_seq.sv - directed self-checking bench for intc_seq
module tb_intc_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  intc_seq_if #(.N_IRQ(4), .ROM_AW(6), .PC_W(32)) bus ();

  intc_seq #(.N_IRQ(4), .ROM_AW(6), .PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_return();
    bus.handler_done = 1'b1;
    tick();
    bus.handler_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++; if (bus.sel_intc !== 1'b0) begin failures++; $display("FAIL rst_sel got=%0b exp=0", bus.sel_intc); end
    checks++; if (bus.rom_addr !== 6'd0) begin failures++; $display("FAIL rst_rom got=%0d exp=0", bus.rom_addr); end
    checks++; if (bus.irq_ack !== 4'd0) begin failures++; $display("FAIL rst_ack got=%b exp=0000", bus.irq_ack); end
    checks++; if (bus.irq_id !== 2'd0) begin failures++; $display("FAIL rst_id got=%0d exp=0", bus.irq_id); end
    checks++; if (bus.pc_restore !== 1'b0) begin failures++; $display("FAIL rst_pcr got=%0b exp=0", bus.pc_restore); end
    checks++; if (bus.epc !== 32'd0) begin failures++; $display("FAIL rst_epc got=%h exp=0", bus.epc); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL rst_ovr got=%0b exp=0", bus.overrun); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
    rst_n = 1'b1;
    // Mid-handler reset at offset 5.
    bus.irq = 4'b0001;
    bus.pc_next = 32'h100;
    tick();
    bus.irq = 4'b0000;
    repeat (5) tick();
    checks++; if (bus.rom_addr !== 6'd5) begin failures++; $display("FAIL mid_rom5 got=%0d exp=5", bus.rom_addr); end
    rst_n = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.sel_intc !== 1'b0) begin failures++; $display("FAIL mid_sel got=%0b exp=0", bus.sel_intc); end
    checks++; if (bus.rom_addr !== 6'd0) begin failures++; $display("FAIL mid_rom got=%0d exp=0", bus.rom_addr); end
    checks++; if (bus.epc !== 32'd0) begin failures++; $display("FAIL mid_epc got=%h exp=0", bus.epc); end
    checks++; if (bus.pc_restore !== 1'b0) begin failures++; $display("FAIL mid_pcr got=%0b exp=0", bus.pc_restore); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.pc_restore !== 1'b0) begin failures++; $display("FAIL mid_pcr_after got=%0b exp=0", bus.pc_restore); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy_after got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_single();
    bus.irq = 4'b0100;
    bus.pc_next = 32'h40;
    tick();
    bus.irq = 4'b0000;
    bus.pc_next = 32'h99;
    checks++; if (bus.sel_intc !== 1'b1) begin failures++; $display("FAIL single_sel got=%0b exp=1", bus.sel_intc); end
    checks++; if (bus.rom_addr !== 6'd32) begin failures++; $display("FAIL single_rom32 got=%0d exp=32", bus.rom_addr); end
    checks++; if (bus.irq_ack !== 4'b0100) begin failures++; $display("FAIL single_ack got=%b exp=0100", bus.irq_ack); end
    checks++; if (bus.epc !== 32'h40) begin failures++; $display("FAIL single_epc got=%h exp=40", bus.epc); end
    checks++; if (bus.irq_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", bus.irq_id); end
    tick();
    checks++; if (bus.rom_addr !== 6'd33) begin failures++; $display("FAIL single_rom33 got=%0d exp=33", bus.rom_addr); end
    checks++; if (bus.irq_ack !== 4'b0000) begin failures++; $display("FAIL single_ack_drop got=%b exp=0000", bus.irq_ack); end
    tick();
    checks++; if (bus.rom_addr !== 6'd34) begin failures++; $display("FAIL single_rom34 got=%0d exp=34", bus.rom_addr); end
    tick();
    checks++; if (bus.rom_addr !== 6'd35) begin failures++; $display("FAIL single_rom35 got=%0d exp=35", bus.rom_addr); end
    bus.handler_done = 1'b1;
    tick();
    bus.handler_done = 1'b0;
    checks++; if (bus.pc_restore !== 1'b1) begin failures++; $display("FAIL single_pcr got=%0b exp=1", bus.pc_restore); end
    checks++; if (bus.epc !== 32'h40) begin failures++; $display("FAIL single_epc_ret got=%h exp=40", bus.epc); end
    checks++; if (bus.sel_intc !== 1'b0) begin failures++; $display("FAIL single_sel_ret got=%0b exp=0", bus.sel_intc); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL single_ovr got=%0b exp=0", bus.overrun); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%0b exp=0", bus.busy); end
    checks++; if (bus.pc_restore !== 1'b0) begin failures++; $display("FAIL single_pcr_drop got=%0b exp=0", bus.pc_restore); end
  endtask

  task automatic test_priority();
    bus.irq = 4'b1010;
    bus.irq_mask = 4'b0010;
    tick();
    bus.irq = 4'b0000;
    bus.irq_mask = 4'b0000;
    checks++; if (bus.irq_id !== 2'd3) begin failures++; $display("FAIL prio_mask_id got=%0d exp=3", bus.irq_id); end
    checks++; if (bus.rom_addr !== 6'd48) begin failures++; $display("FAIL prio_mask_rom got=%0d exp=48", bus.rom_addr); end
    checks++; if (bus.irq_ack !== 4'b1000) begin failures++; $display("FAIL prio_mask_ack got=%b exp=1000", bus.irq_ack); end
    do_return();
    bus.irq = 4'b1010;
    tick();
    bus.irq = 4'b0000;
    checks++; if (bus.irq_id !== 2'd1) begin failures++; $display("FAIL prio_id got=%0d exp=1", bus.irq_id); end
    checks++; if (bus.rom_addr !== 6'd16) begin failures++; $display("FAIL prio_rom got=%0d exp=16", bus.rom_addr); end
    checks++; if (bus.irq_ack !== 4'b0010) begin failures++; $display("FAIL prio_ack got=%b exp=0010", bus.irq_ack); end
    do_return();
  endtask

  task automatic test_overrun();
    bus.irq = 4'b0001;
    tick();
    bus.irq = 4'b0000;
    checks++; if (bus.rom_addr !== 6'd0) begin failures++; $display("FAIL ovr_rom0 got=%0d exp=0", bus.rom_addr); end
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++; if (bus.rom_addr !== 6'(i) || bus.sel_intc !== 1'b1) begin failures++; $display("FAIL ovr_walk got=%0d exp=%0d", bus.rom_addr, i); end
    end
    tick();
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_pulse got=%0b exp=1", bus.overrun); end
    checks++; if (bus.pc_restore !== 1'b1) begin failures++; $display("FAIL ovr_pcr got=%0b exp=1", bus.pc_restore); end
    checks++; if (bus.sel_intc !== 1'b0 || bus.rom_addr === 6'd16) begin failures++; $display("FAIL ovr_noaddr16 got_sel=%0b got_rom=%0d exp_sel=0", bus.sel_intc, bus.rom_addr); end
    tick();
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_drop got=%0b exp=0", bus.overrun); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ovr_idle got=%0b exp=0", bus.busy); end
    // handler_done on the slot's last word is a normal return.
    bus.irq = 4'b0010;
    tick();
    bus.irq = 4'b0000;
    repeat (15) tick();
    checks++; if (bus.rom_addr !== 6'd31) begin failures++; $display("FAIL edge_rom31 got=%0d exp=31", bus.rom_addr); end
    bus.handler_done = 1'b1;
    tick();
    bus.handler_done = 1'b0;
    checks++; if (bus.pc_restore !== 1'b1 || bus.overrun !== 1'b0) begin failures++; $display("FAIL edge_done got_pcr=%0b got_ovr=%0b exp_pcr=1 exp_ovr=0", bus.pc_restore, bus.overrun); end
    tick();
  endtask

  task automatic test_stall();
    bus.irq = 4'b0010;
    tick();
    bus.irq = 4'b0000;
    checks++; if (bus.irq_ack !== 4'b0010) begin failures++; $display("FAIL stall_ack0 got=%b exp=0010", bus.irq_ack); end
    bus.stall = 1'b1;
    tick();
    checks++; if (bus.irq_ack !== 4'b0010 || bus.rom_addr !== 6'd16) begin failures++; $display("FAIL stall_ack_hold got_ack=%b got_rom=%0d exp=0010/16", bus.irq_ack, bus.rom_addr); end
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.irq_ack !== 4'b0000 || bus.rom_addr !== 6'd17) begin failures++; $display("FAIL stall_resume got_ack=%b got_rom=%0d exp=0000/17", bus.irq_ack, bus.rom_addr); end
    tick();
    checks++; if (bus.rom_addr !== 6'd18) begin failures++; $display("FAIL stall_rom18 got=%0d exp=18", bus.rom_addr); end
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.rom_addr !== 6'd18) begin failures++; $display("FAIL stall_hold got=%0d exp=18", bus.rom_addr); end
    end
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.rom_addr !== 6'd19) begin failures++; $display("FAIL stall_rom19 got=%0d exp=19", bus.rom_addr); end
    bus.handler_done = 1'b1;
    tick();
    bus.handler_done = 1'b0;
    bus.stall = 1'b1;
    tick();
    checks++; if (bus.pc_restore !== 1'b1) begin failures++; $display("FAIL stall_pcr_hold got=%0b exp=1", bus.pc_restore); end
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL stall_idle got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    bus.irq = 4'b0100;
    tick();
    checks++; if (bus.rom_addr !== 6'd32) begin failures++; $display("FAIL b2b_first got=%0d exp=32", bus.rom_addr); end
    bus.handler_done = 1'b1;
    tick();
    bus.handler_done = 1'b0;
    checks++; if (bus.pc_restore !== 1'b1) begin failures++; $display("FAIL b2b_ret got=%0b exp=1", bus.pc_restore); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.sel_intc !== 1'b0) begin failures++; $display("FAIL b2b_idle got_busy=%0b exp=0", bus.busy); end
    tick();
    checks++; if (bus.busy !== 1'b1 || bus.rom_addr !== 6'd32 || bus.irq_ack !== 4'b0100) begin failures++; $display("FAIL b2b_reentry got_rom=%0d got_ack=%b exp=32/0100", bus.rom_addr, bus.irq_ack); end
    bus.irq = 4'b0000;
    do_return();
    bus.ien = 1'b0;
    bus.irq = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ien_off got=%0b exp=0", bus.busy); end
    end
    bus.irq = 4'b0000;
    bus.ien = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.irq = 4'b0000;
    bus.irq_mask = 4'b0000;
    bus.ien = 1'b1;
    bus.stall = 1'b0;
    bus.pc_next = 32'h1234;
    bus.handler_done = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_overrun();
    test_stall();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
